// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and parity helper.
// The optional parity state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO shared by UART paths. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate count. A pop is applied
// before a push, so a full FIFO accepts a push in the same cycle it is popped;
// a pop on an empty FIFO is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Push,
  input  logic             i_Pop,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign o_Empty = (wr_ptr == rd_ptr);
  assign o_Full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = i_Pop && !o_Empty;
  assign do_push = i_Push && (!o_Full || do_pop);
  assign o_Data  = o_Empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both pointers wrap modulo 2*DEPTH.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge i_Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_Data;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, with a receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_ParityErr port.
//
// Handshake: a byte leaves the FIFO on every cycle where o_Valid and i_Ready
// are both 1; while o_Valid=1 and i_Ready=0, o_Valid and o_Data hold stable.
// o_State exposes the receiver FSM state for debug.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_UART_RX,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  input  logic       i_Ready,
  output logic       o_FrameErr,
  output logic       o_Overrun,
  input  logic       i_ClrErr,
`ifdef UART_RX_PARITY_EN
  output logic       o_ParityErr,
`endif
  output logic [2:0] o_State
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rx_s;
  uart_state_t               state, state_d;
  logic [15:0]               clk_cnt, cnt_d;
  logic [2:0]                bit_idx, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      armed, armed_d;
  logic                      push;
  logic                      ferr_set;
  logic                      ovr_set;
  logic                      fifo_full;
  logic                      fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad, par_bad_d;
  logic                      perr_set;
`endif

  assign rx_s    = sync_q[1];
  assign o_State = state;
  assign o_Valid = !fifo_empty;
  // A write into a full FIFO only succeeds if the head is popped the same cycle.
  assign ovr_set = push && fifo_full && !i_Ready;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], i_UART_RX};
  end

  // FSM registers: state, bit timer, bit index, shift register, break guard.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      armed   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      clk_cnt <= cnt_d;
      bit_idx <= bit_d;
      shift_q <= shift_d;
      armed   <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_d;
`endif
    end
  end

  // Next-state logic: mid-bit sampling, byte assembly and error detection.
  always_comb begin
    state_d  = state;
    cnt_d    = clk_cnt + 16'd1;
    bit_d    = bit_idx;
    shift_d  = shift_q;
    armed_d  = armed || rx_s;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad;
    perr_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_d = '0;
        // A start is accepted only once the line has been seen high after a
        // framing error, so a held break cannot retrigger reception.
        if (!rx_s && armed) begin
          state_d = START;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START: begin
        if (clk_cnt == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == FULL_M1) begin
          cnt_d   = '0;
          state_d = STOP;
          if (rx_s != even_parity(shift_q)) begin
            perr_set  = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (clk_cnt == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad;
`else
            push = 1'b1;
`endif
          end else begin
            ferr_set = 1'b1;
            armed_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sticky error flags; a new error event wins over a simultaneous clear.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_FrameErr <= 1'b0;
      o_Overrun  <= 1'b0;
    end else begin
      if (ferr_set)      o_FrameErr <= 1'b1;
      else if (i_ClrErr) o_FrameErr <= 1'b0;
      if (ovr_set)       o_Overrun  <= 1'b1;
      else if (i_ClrErr) o_Overrun  <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity error flag, same set-over-clear priority as the others.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)         o_ParityErr <= 1'b0;
    else if (perr_set) o_ParityErr <= 1'b1;
    else if (i_ClrErr) o_ParityErr <= 1'b0;
  end
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Push  (push),
    .i_Pop   (i_Ready),
    .i_Data  (shift_q),
    .o_Data  (o_Data),
    .o_Full  (fifo_full),
    .o_Empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx (CLKS_PER_BIT=8, FIFO_DEPTH=4). A frame-level model predicts
// when each byte lands in the receive FIFO and which sticky flags are set; a
// compare process checks every output on every falling edge. Define
// UART_RX_PARITY_EN to build the parity variant.
module tb_uart_rx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int HALF  = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Edges from driving the start bit low to a bit sample: 2 synchronizer
  // flops, 1 edge for IDLE to notice, half a bit, then whole bits.
  localparam int PAR_LAT  = 3 + HALF + 9 * CPB;
  localparam int STOP_LAT = 3 + HALF + (NB - 1) * CPB;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    int         kind;   // 0 good byte, 1 framing error, 2 parity error
  } ev_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       rx = 1'b1;
  logic       i_Ready = 1'b0;
  logic       i_ClrErr = 1'b0;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_FrameErr;
  logic       o_Overrun;
  logic [2:0] state_dbg;
`ifdef UART_RX_PARITY_EN
  logic       o_ParityErr;
`endif

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (i_Rst),
    .i_UART_RX   (rx),
    .o_Data      (o_Data),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .o_FrameErr  (o_FrameErr),
    .o_Overrun   (o_Overrun),
    .i_ClrErr    (i_ClrErr),
`ifdef UART_RX_PARITY_EN
    .o_ParityErr (o_ParityErr),
`endif
    .o_State     (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int         n_vec  = 0;
  int         n_miss = 0;
  int         cyc    = 0;
  bit         chk_en = 1'b0;
  logic [7:0] exp_q[$];
  ev_t        pend[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;
  logic       m_perr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: on each rising edge apply pop, then any frame completing this edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (i_Rst) begin
        exp_q.delete();
        pend.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
      end else begin
        logic fs, os, ps;
        ev_t  ev;
        fs = 1'b0; os = 1'b0; ps = 1'b0;
        if (exp_q.size() > 0 && i_Ready) void'(exp_q.pop_front());
        while (pend.size() > 0 && pend[0].cyc <= cyc) begin
          ev = pend.pop_front();
          if (ev.kind == 0) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ev.data);
            else os = 1'b1;
          end else if (ev.kind == 1) begin
            fs = 1'b1;
          end else begin
            ps = 1'b1;
          end
        end
        m_ferr = fs ? 1'b1 : (i_ClrErr ? 1'b0 : m_ferr);
        m_ovr  = os ? 1'b1 : (i_ClrErr ? 1'b0 : m_ovr);
        m_perr = ps ? 1'b1 : (i_ClrErr ? 1'b0 : m_perr);
      end
    end
  end

  // Compare process: every output against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("valid", 32'(o_Valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("data", 32'(o_Data), 32'(exp_q[0]));
        check("frame_err", 32'(o_FrameErr), 32'(m_ferr));
        check("overrun", 32'(o_Overrun), 32'(m_ovr));
`ifdef UART_RX_PARITY_EN
        check("parity_err", 32'(o_ParityErr), 32'(m_perr));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one frame bit by bit. rst_at >= 0 aborts the frame with a reset at
  // that cycle; rdy_at_stop / clr_at_stop pulse i_Ready / i_ClrErr on the
  // edge that samples the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            input int rst_at, input logic rdy_at_stop, input logic clr_at_stop);
    logic [10:0] bits;
    int          t0;
    logic        old_rdy;
    t0      = cyc;
    old_rdy = i_Ready;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ par_flip;
    bits[10] = stop_b;
`else
    bits[9]  = stop_b;
`endif
    if (rst_at < 0) begin
`ifdef UART_RX_PARITY_EN
      if (par_flip) pend.push_back('{t0 + PAR_LAT, d, 2});
      else
`endif
      if (!stop_b) pend.push_back('{t0 + STOP_LAT, d, 1});
      else         pend.push_back('{t0 + STOP_LAT, d, 0});
    end
    for (int c = 0; c < NB * CPB; c++) begin
      rx = bits[c / CPB];
      if (c == rst_at) begin
        i_Rst = 1'b1;
        rx    = 1'b1;
        tick();
        i_Rst    = 1'b0;
        i_Ready  = old_rdy;
        i_ClrErr = 1'b0;
        return;
      end
      if (c == STOP_LAT - 1) begin
        if (rdy_at_stop) i_Ready  = 1'b1;
        if (clr_at_stop) i_ClrErr = 1'b1;
      end else if (c == STOP_LAT) begin
        i_Ready  = old_rdy;
        i_ClrErr = 1'b0;
      end
      tick();
    end
    rx = 1'b1;
  endtask

  task automatic good(input logic [7:0] d);
    send_frame(d, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    idle(2 * CPB);
  endtask

  task automatic pulse_clr();
    i_ClrErr = 1'b1;
    tick();
    i_ClrErr = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] d);
    check("drain_valid", 32'(o_Valid), 32'd1);
    check("drain_data", 32'(o_Data), 32'(d));
    i_Ready = 1'b1;
    tick();
    i_Ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pats [4];

  initial begin
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h80; pats[3] = 8'h6D;
    i_Rst = 1'b1;
    tick(); tick(); tick();
    chk_en = 1'b1;
    i_Rst  = 1'b0;
    check("rst_valid", 32'(o_Valid), 32'd0);
    check("rst_data", 32'(o_Data), 32'h00);
    check("rst_ferr", 32'(o_FrameErr), 32'd0);
    check("rst_ovr", 32'(o_Overrun), 32'd0);
    idle(4);

    // 0xA5 in 8N1; latency is pinned by the per-cycle compare.
    send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    check("a5_valid", 32'(o_Valid), 32'd1);
    check("a5_data", 32'(o_Data), 32'hA5);
    check("a5_ferr", 32'(o_FrameErr), 32'd0);
    check("a5_ovr", 32'(o_Overrun), 32'd0);
    idle(2 * CPB);
    pop_expect(8'hA5);
    check("a5_popped", 32'(o_Valid), 32'd0);

    // 3-cycle glitch on an idle line.
    rx = 1'b0;
    tick(); tick(); tick();
    idle(3 * CPB);
    check("glitch_valid", 32'(o_Valid), 32'd0);
    check("glitch_ferr", 32'(o_FrameErr), 32'd0);

    // Framing error followed by a held break, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    rx = 1'b0;
    check("ferr_set", 32'(o_FrameErr), 32'd1);
    check("ferr_valid", 32'(o_Valid), 32'd0);
    for (int i = 0; i < 3 * CPB; i++) tick();
    idle(CPB);
    send_frame(8'h11, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    idle(CPB);
    pop_expect(8'h11);
    pulse_clr();
    check("ferr_clr", 32'(o_FrameErr), 32'd0);

    // Clear coinciding with a new framing error: the set wins.
    send_frame(8'h5A, 1'b0, 1'b0, -1, 1'b0, 1'b1);
    check("set_wins", 32'(o_FrameErr), 32'd1);
    idle(2 * CPB);
    pulse_clr();

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) good(8'(i));
    check("ovr_set", 32'(o_Overrun), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    check("drained", 32'(o_Valid), 32'd0);
    pulse_clr();

    // Push and pop together on a full FIFO: no overrun.
    good(8'h10); good(8'h20); good(8'h30); good(8'h40);
    send_frame(8'h50, 1'b1, 1'b0, -1, 1'b1, 1'b0);
    idle(CPB);
    check("full_pushpop_ovr", 32'(o_Overrun), 32'd0);
    pop_expect(8'h20); pop_expect(8'h30); pop_expect(8'h40); pop_expect(8'h50);

    // Consumer always ready: push and pop together on an empty FIFO.
    i_Ready = 1'b1;
    for (int i = 0; i < 4; i++) good(pats[i]);
    send_frame(8'h99, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    tick();
    check("empty_pushpop", 32'(o_Valid), 32'd0);
    i_Ready = 1'b0;
    idle(CPB);

    // Reset during data bit 3 of 0x7E, then 0x42.
    send_frame(8'h7E, 1'b1, 1'b0, 4 * CPB + 3, 1'b0, 1'b0);
    idle(2 * CPB);
    check("rst_abort_valid", 32'(o_Valid), 32'd0);
    send_frame(8'h42, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    idle(CPB);
    pop_expect(8'h42);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity is 1; send 0 first.
    send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    idle(CPB);
    check("perr_set", 32'(o_ParityErr), 32'd1);
    check("perr_drop", 32'(o_Valid), 32'd0);
    send_frame(8'h07, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    idle(CPB);
    pop_expect(8'h07);
    pulse_clr();
    check("perr_clr", 32'(o_ParityErr), 32'd0);
`endif

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog: the stimulus is a fixed sequence, so this only guards a stall.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
